key_debouncer: RTL and testbench

//  Conditions the raw active-low KEY[3:0] push-buttons before they reach a DUT in the emulator.
//  - Synchronises, debounces and edge-detects each key.
//  - Outputs a clean active-high level plus one-cycle press/release pulses.
//  - Sits between the board/emulator KEY inputs and user logic on CLK.

---
 rtl/key_debouncer_pkg.sv | 15 +
 rtl/key_debounce_channel.sv | 126 ++++++++++++
 rtl/key_debouncer.sv | 36 +++
 tb/tb_key_debouncer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the KEY[] debouncer.
// Imported by key_debounce_channel and key_debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } kd_state_t;

  // Raw board buttons pull low when pressed.
  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: synchroniser, debounce FSM and registered level/press/release outputs.
// Optional auto-repeat when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  kd_state_t              r_state;
  kd_state_t              w_state_nxt;
  logic                   w_pressed;
  logic                   w_cnt_clr;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_rpt_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
  end

  assign w_pressed = (r_sync[SYNC_STAGES-1] == KEY_ACTIVE_LEVEL);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = DB_PRESS;
          w_cnt_clr   = 1'b1;
        end
      end
      DB_PRESS: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_clr   = 1'b1;
          w_press_nxt = 1'b1;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = DB_RELEASE;
          w_cnt_clr   = 1'b1;
        end else begin
          w_press_nxt = w_rpt_fire;
        end
      end
      default: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_cnt_clr     = 1'b1;
          w_release_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      o_level   <= (w_state_nxt == HELD) || (w_state_nxt == DB_RELEASE);
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if ((r_state == DB_PRESS) || (r_state == DB_RELEASE))
        r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0] r_rpt;

  assign w_rpt_fire = (r_state == HELD) && (r_rpt == RPT_W'(REPEAT_DELAY - 1));

  // After each repeat the counter rewinds so the next fire is REPEAT_PERIOD cycles later.
  always_ff @(posedge CLK) begin
    if (RST)
      r_rpt <= '0;
    else if (((r_state == DB_PRESS) && (w_state_nxt == HELD)) || (w_state_nxt == IDLE))
      r_rpt <= '0;
    else if ((r_state == HELD) && (w_state_nxt == HELD))
      r_rpt <= w_rpt_fire ? RPT_W'(REPEAT_DELAY - REPEAT_PERIOD) : r_rpt + 1'b1;
  end
`else
  logic w_unused_rpt;

  assign w_rpt_fire   = 1'b0;
  assign w_unused_rpt = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low push-buttons into clean level and press/release pulses.
// Build with KEY_DEBOUNCER_AUTOREPEAT_EN defined to add held-key auto-repeat presses.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .CLK      (CLK),
      .RST      (RST),
      .i_key    (KEY[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: expected pulse events are queued when keys are driven.
// Repeat expectations follow KEY_DEBOUNCER_AUTOREPEAT_EN.
module tb_key_debouncer;

  localparam int LAT = 19;  // SYNC_STAGES + 1 + DEBOUNCE_CYCLES

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int unsigned edge_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned d;
  ev_t         sb[$];

  key_debouncer #(
    .N_KEYS         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .REPEAT_DELAY   (50),
    .REPEAT_PERIOD  (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic void expect_ev(input int unsigned c, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r;
    sb.push_back(e);
  endfunction

  // Drive KEY just after a falling edge; d is the last rising edge before it.
  task automatic set_key(input logic [3:0] v);
    @(negedge CLK);
    KEY = v;
    d   = edge_cnt;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if ((|(key_press | key_release)) === 1'b1 || $isunknown({key_press, key_release})) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {24'd0, key_press, key_release}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_edge", edge_cnt, e.cyc);
        check("pulse_press", {28'd0, key_press}, {28'd0, e.press});
        check("pulse_release", {28'd0, key_release}, {28'd0, e.rel});
      end
    end
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_level", {28'd0, key_level}, 32'd0);
    check("rst_press", {28'd0, key_press}, 32'd0);
    check("rst_release", {28'd0, key_release}, 32'd0);
    RST = 1'b0;
    wait_cyc(2);

    // 1. Clean press then release on key 0
    set_key(4'b1110);
    expect_ev(d + LAT, 4'b0001, 4'b0000);
    wait_cyc(LAT - 1);
    check("t1_level_before", {28'd0, key_level}, 32'd0);
    wait_cyc(40 - LAT + 1);
    check("t1_level_held", {28'd0, key_level}, 32'h1);
    set_key(4'b1111);
    expect_ev(d + LAT, 4'b0000, 4'b0001);
    wait_cyc(LAT - 1);
    check("t1_level_until_release", {28'd0, key_level}, 32'h1);
    wait_cyc(6);
    check("t1_level_after", {28'd0, key_level}, 32'd0);

    // 2. Bounce on key 1: low 5, high 3, then low
    set_key(4'b1101);
    wait_cyc(4);
    set_key(4'b1111);
    wait_cyc(2);
    set_key(4'b1101);
    expect_ev(d + LAT, 4'b0010, 4'b0000);
    wait_cyc(25);
    check("t2_level", {28'd0, key_level}, 32'h2);
    set_key(4'b1111);
    expect_ev(d + LAT, 4'b0000, 4'b0010);
    wait_cyc(25);

    // 3. Short glitch on key 2
    set_key(4'b1011);
    wait_cyc(9);
    set_key(4'b1111);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      check("t3_level2", {31'd0, key_level[2]}, 32'd0);
    end

    // 4. All keys pressed together
    set_key(4'b0000);
    expect_ev(d + LAT, 4'b1111, 4'b0000);
    wait_cyc(20);
    check("t4_level", {28'd0, key_level}, 32'hF);
    set_key(4'b0111);
    expect_ev(d + LAT, 4'b0000, 4'b0111);
    wait_cyc(25);
    check("t5_level_pre", {28'd0, key_level}, 32'h8);

    // 5. Reset while key 3 is held
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_level", {28'd0, key_level}, 32'd0);
    check("t5_rst_press", {28'd0, key_press}, 32'd0);
    check("t5_rst_release", {28'd0, key_release}, 32'd0);
    RST = 1'b0;
    d   = edge_cnt;
    expect_ev(d + LAT, 4'b1000, 4'b0000);
    wait_cyc(LAT + 3);
    check("t5_level_again", {28'd0, key_level}, 32'h8);
    set_key(4'b1111);
    expect_ev(d + LAT, 4'b0000, 4'b1000);
    wait_cyc(25);

    // 6. Long hold on key 0 (repeat pulses only with the macro)
    set_key(4'b1110);
    expect_ev(d + LAT, 4'b0001, 4'b0000);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    for (int k = 0; k < 5; k++) expect_ev(d + LAT + 50 + 10 * k, 4'b0001, 4'b0000);
`endif
    wait_cyc(LAT + 92);
    check("t6_level_held", {28'd0, key_level}, 32'h1);
    set_key(4'b1111);
    expect_ev(d + LAT, 4'b0000, 4'b0001);
    wait_cyc(30);
    check("t6_level_after", {28'd0, key_level}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
